// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 32-way round-robin mux arbiter.
// Sizes here are used by the picker and the arbiter top.
package mux_arb_pkg;

  localparam int NUM_REQ = 32;
  localparam int SEL_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  function automatic int hold_w(input int mh);
    return (mh < 1) ? 1 : $clog2(mh + 1);
  endfunction

  localparam int MAX_HOLD_DEF = 16;
  typedef logic [hold_w(MAX_HOLD_DEF)-1:0] hold_cnt_t;

endpackage

// File: rtl/mux_32_rr_arb_pick.sv
// Rotating priority encoder: first set request at or above ptr,
// wrapping from 31 back to 0.
module rr_pick_32
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] w_k;

  // Scan high offset to low so the nearest hit wins last.
  always_comb begin
    w_k = '0;
    idx = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_k = ptr + SEL_W'(i);
      if (req[w_k]) idx = w_k;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_32_rr_arb.sv
// Round-robin owner sequencer for mux_32: one-hot grant, binary select,
// hold limit and a bubble cycle between owners.
module mux_32_rr_arb
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               gnt_valid
);

  localparam int HW = hold_w(MAX_HOLD);
  localparam logic [HW-1:0] CNT_SAT = HW'(MAX_HOLD);
  localparam logic [HW-1:0] CNT_LIM = HW'(MAX_HOLD - 1);

  state_t             r_state, w_state;
  logic [NUM_REQ-1:0] r_gnt, w_gnt;
  logic [SEL_W-1:0]   r_sel, w_sel;
  logic [SEL_W-1:0]   r_ptr, w_ptr;
  logic [HW-1:0]      r_cnt, w_cnt;
  logic               r_gv, w_gv;

  logic               w_any;
  logic [SEL_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_oth;
  logic               w_exp;
  logic               w_rel;

  rr_pick_32 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_oth = req & ~(NUM_REQ'(1) << r_sel);
  assign w_exp = (MAX_HOLD != 0) && (r_cnt == CNT_LIM) && (|w_oth);
  assign w_rel = done | ~req[r_sel] | w_exp;

  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_sel   = r_sel;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    w_gv    = r_gv;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt   = NUM_REQ'(1) << w_idx;
          w_sel   = w_idx;
          w_gv    = 1'b1;
          w_cnt   = '0;
          w_state = GRANT;
        end
      end
      GRANT: begin
        if (r_cnt != CNT_SAT) w_cnt = r_cnt + 1'b1;
        if (w_rel) begin
          w_gnt   = '0;
          w_gv    = 1'b0;
          w_ptr   = r_sel + 1'b1;
          w_state = GAP;
        end
      end
      GAP:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gv    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_sel   <= w_sel;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_gv    <= w_gv;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign gnt_valid = r_gv;

endmodule

// File: tb/tb_mux_32_rr_arb.sv
// Bench for mux_32_rr_arb: vector table, directed corner sequences
// and random traffic against an owner/tenure reference model.
module tb_mux_32_rr_arb;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req = '0;
  logic        done = 1'b0;
  logic [31:0] gnt;
  logic [4:0]  sel;
  logic        gnt_valid;

  int n_chk = 0;
  int n_fail = 0;

  mux_32_rr_arb #(.MAX_HOLD(MH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // Reference: owner index (-1 none), bubble flag, pointer, tenure length.
  int m_own = -1;
  bit m_gap = 0;
  int m_ptr = 0;
  int m_ten = 0;
  int m_sel = 0;

  task automatic model_step();
    logic [31:0] oth;
    if (rst) begin
      m_own = -1; m_gap = 0; m_ptr = 0; m_ten = 0; m_sel = 0;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < 32; k++) begin
        int j;
        j = (m_ptr + k) % 32;
        if (req[j] && m_own < 0) begin
          m_own = j; m_sel = j; m_ten = 1;
        end
      end
    end else begin
      oth = req;
      oth[m_own] = 1'b0;
      if (done || !req[m_own] || (MH != 0 && m_ten == MH && oth != 0)) begin
        m_ptr = (m_own + 1) % 32;
        m_own = -1;
        m_gap = 1;
      end else begin
        m_ten++;
      end
    end
  endtask

  function automatic logic [31:0] m_gnt();
    return (m_own >= 0) ? (32'h1 << m_own) : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] q, input logic d);
    rst = r; req = q; done = d;
    @(posedge clk);
    model_step();
    #1;
    chk("mdl_gnt", gnt, m_gnt());
    chk("mdl_sel", {27'b0, sel}, 32'(m_sel));
    chk("mdl_gv", {31'b0, gnt_valid}, {31'b0, m_own >= 0});
  endtask

  typedef struct {
    logic        r;
    logic [31:0] q;
    logic        d;
    logic [31:0] g;
    logic [4:0]  s;
    logic        v;
  } vec_t;

  vec_t tv[22];

  initial begin
    logic [31:0] q;
    logic        r, d;

    tv[0]  = '{1'b1, 32'h0,         1'b0, 32'h0,         5'd0,  1'b0};
    tv[1]  = '{1'b0, 32'h4,         1'b0, 32'h4,         5'd2,  1'b1};
    tv[2]  = '{1'b0, 32'h4,         1'b1, 32'h0,         5'd2,  1'b0};
    tv[3]  = '{1'b0, 32'hC,         1'b0, 32'h0,         5'd2,  1'b0};
    tv[4]  = '{1'b0, 32'hC,         1'b0, 32'h8,         5'd3,  1'b1};
    tv[5]  = '{1'b0, 32'hC,         1'b1, 32'h0,         5'd3,  1'b0};
    tv[6]  = '{1'b0, 32'h0,         1'b0, 32'h0,         5'd3,  1'b0};
    tv[7]  = '{1'b0, 32'h0,         1'b0, 32'h0,         5'd3,  1'b0};
    tv[8]  = '{1'b0, 32'h8000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b1};
    tv[9]  = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd31, 1'b0};
    tv[10] = '{1'b0, 32'h8000_0001, 1'b0, 32'h0,         5'd31, 1'b0};
    tv[11] = '{1'b0, 32'h8000_0001, 1'b0, 32'h1,         5'd0,  1'b1};
    tv[12] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0};
    tv[13] = '{1'b0, 32'h8000_0001, 1'b0, 32'h0,         5'd0,  1'b0};
    tv[14] = '{1'b0, 32'h8000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b1};
    tv[15] = '{1'b0, 32'h8000_0001, 1'b1, 32'h0,         5'd31, 1'b0};
    tv[16] = '{1'b0, 32'h8000_0001, 1'b0, 32'h0,         5'd31, 1'b0};
    tv[17] = '{1'b0, 32'h8000_0001, 1'b0, 32'h1,         5'd0,  1'b1};
    tv[18] = '{1'b0, 32'h8000_0000, 1'b0, 32'h0,         5'd0,  1'b0};
    tv[19] = '{1'b0, 32'h0,         1'b1, 32'h0,         5'd0,  1'b0};
    tv[20] = '{1'b0, 32'h0,         1'b1, 32'h0,         5'd0,  1'b0};
    tv[21] = '{1'b0, 32'h0,         1'b0, 32'h0,         5'd0,  1'b0};

    for (int i = 0; i < 22; i++) begin
      cyc(tv[i].r, tv[i].q, tv[i].d);
      chk($sformatf("tv%0d_gnt", i), gnt, tv[i].g);
      chk($sformatf("tv%0d_sel", i), {27'b0, sel}, {27'b0, tv[i].s});
      chk($sformatf("tv%0d_gv", i), {31'b0, gnt_valid}, {31'b0, tv[i].v});
    end

    // Hold limit: two requesters alternate in 4-cycle tenures.
    cyc(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h3, 1'b0);
      chk("hold_own0", {26'b0, gnt_valid, sel}, {26'b0, 1'b1, 5'd0});
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 32'h3, 1'b0);
      chk("hold_gap", {31'b0, gnt_valid}, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h3, 1'b0);
      chk("hold_own1", {26'b0, gnt_valid, sel}, {26'b0, 1'b1, 5'd1});
    end
    cyc(1'b0, 32'h3, 1'b0);
    chk("hold_rel1", {31'b0, gnt_valid}, 32'h0);

    // Sole requester keeps the grant indefinitely.
    cyc(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 120; i++) begin
      cyc(1'b0, 32'h10, 1'b0);
      chk("sole_gnt", gnt, 32'h10);
    end

    // Reset while requester 17 owns the mux.
    cyc(1'b1, 32'h0, 1'b0);
    cyc(1'b0, 32'h0002_0000, 1'b0);
    chk("r17_sel", {27'b0, sel}, 32'd17);
    cyc(1'b0, 32'h0002_0000, 1'b0);
    cyc(1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("rmid_gnt", gnt, 32'h0);
    chk("rmid_sel", {27'b0, sel}, 32'h0);
    chk("rmid_gv", {31'b0, gnt_valid}, 32'h0);
    cyc(1'b0, 32'hFFFF_FFFF, 1'b0);
    chk("rmid_first", gnt, 32'h1);

    // Random traffic with sticky requests.
    q = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: q = 32'h0;
          1: q = 32'h1 << $urandom_range(0, 31);
          2: q = $urandom();
          default: q = $urandom() & $urandom() & $urandom();
        endcase
      end
      cyc(r, q, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
